// File: rtl/biriscv_inst_queue_pkg.sv
// biriscv_inst_queue_pkg: shared decoded-instruction info bit order and queue entry layout
package biriscv_inst_queue_pkg;
  localparam int INFO_FAULT_FETCH = 0;
  localparam int INFO_FAULT_PAGE  = 1;
  localparam int INFO_EXEC        = 2;
  localparam int INFO_LSU         = 3;
  localparam int INFO_BRANCH      = 4;
  localparam int INFO_MUL         = 5;
  localparam int INFO_DIV         = 6;
  localparam int INFO_CSR         = 7;
  localparam int INFO_RD_VALID    = 8;
  localparam int INFO_INVALID     = 9;
  localparam int INFO_MULE        = 10;
  localparam int INFO_CBM         = 11;
  localparam int INFO_W           = 12;
  localparam int INSTR_W          = 32;
  localparam int PC_W             = 32;
  localparam int ENTRY_W          = INFO_W + PC_W + INSTR_W;
  typedef struct packed {
    logic [INFO_W-1:0]  info;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/biriscv_inst_queue.sv
// biriscv_inst_queue: dual-lane in-order instruction queue between decode and issue
module biriscv_inst_queue
  import biriscv_inst_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in0_valid_i,
  input  logic               in1_valid_i,
  output logic               in0_accept_o,
  output logic               in1_accept_o,
  input  logic [31:0]        in0_instr_i,
  input  logic [31:0]        in1_instr_i,
  input  logic [31:0]        in0_pc_i,
  input  logic [31:0]        in1_pc_i,
  input  logic [INFO_W-1:0]  in0_info_i,
  input  logic [INFO_W-1:0]  in1_info_i,
  output logic               out0_valid_o,
  output logic               out1_valid_o,
  input  logic               out0_accept_i,
  input  logic               out1_accept_i,
  output logic [31:0]        out0_instr_o,
  output logic [31:0]        out1_instr_o,
  output logic [31:0]        out0_pc_o,
  output logic [31:0]        out1_pc_o,
  output logic [INFO_W-1:0]  out0_info_o,
  output logic [INFO_W-1:0]  out1_info_o,
  output logic [DEPTH_W:0]   level_o
);
  localparam int DM1 = DEPTH - 1;
  localparam logic [DEPTH_W:0] CNT_FULL = DEPTH[DEPTH_W:0];
  localparam logic [DEPTH_W:0] CNT_AF   = DM1[DEPTH_W:0];
  entry_t             storage [DEPTH];
  logic [DEPTH_W-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  logic [DEPTH_W:0]   count;
  logic               push0, push1, pop0, pop1;
  logic [1:0]         push_cnt, pop_cnt;
  entry_t             head0, head1;
  assign in0_accept_o = count < CNT_FULL;
  assign in1_accept_o = count < CNT_AF;
  assign out0_valid_o = count != '0;
  assign out1_valid_o = count > (DEPTH_W+1)'(1);
  assign level_o      = count;
  assign push0    = in0_valid_i & in0_accept_o;
  assign push1    = in1_valid_i & in1_accept_o;
  assign pop0     = out0_accept_i & out0_valid_o;
  // a second-slot consume only counts alongside the first, keeping issue in order
  assign pop1     = pop0 & out1_accept_i & out1_valid_o;
  assign push_cnt = {1'b0, push0} + {1'b0, push1};
  assign pop_cnt  = {1'b0, pop0} + {1'b0, pop1};
  assign rd_ptr1  = rd_ptr + DEPTH_W'(1);
  assign wr_ptr1  = wr_ptr + DEPTH_W'(1);
  assign head0    = storage[rd_ptr];
  assign head1    = storage[rd_ptr1];
  assign out0_instr_o = head0.instr;
  assign out0_pc_o    = head0.pc;
  assign out0_info_o  = head0.info;
  assign out1_instr_o = head1.instr;
  assign out1_pc_o    = head1.pc;
  assign out1_info_o  = head1.info;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + DEPTH_W'(pop_cnt);
      wr_ptr <= wr_ptr + DEPTH_W'(push_cnt);
      count  <= count + (DEPTH_W+1)'(push_cnt) - (DEPTH_W+1)'(pop_cnt);
    end
  end
  // storage is never reset; a lone lane-1 push takes the lane-0 slot
  always_ff @(posedge clk_i) begin
    if (push0) storage[wr_ptr] <= '{info: in0_info_i, pc: in0_pc_i, instr: in0_instr_i};
    if (push1) storage[push0 ? wr_ptr1 : wr_ptr] <= '{info: in1_info_i, pc: in1_pc_i, instr: in1_instr_i};
  end
endmodule

// File: tb/tb_biriscv_inst_queue.sv
// tb_biriscv_inst_queue: randomized bench checking the queue against a simple FIFO model
module tb_biriscv_inst_queue;
  logic        clk = 0, rst = 0, flush = 0;
  logic        in0_v = 0, in1_v = 0, in0_acc, in1_acc;
  logic [31:0] in0_instr = 0, in1_instr = 0, in0_pc = 0, in1_pc = 0;
  logic [11:0] in0_info = 0, in1_info = 0;
  logic        out0_v, out1_v, out0_acc = 0, out1_acc = 0;
  logic [31:0] out0_instr, out1_instr, out0_pc, out1_pc;
  logic [11:0] out0_info, out1_info;
  logic [3:0]  level;
  logic [75:0] model [$];
  int          pass_cnt = 0, total_cnt = 0;

  biriscv_inst_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in0_valid_i(in0_v), .in1_valid_i(in1_v),
    .in0_accept_o(in0_acc), .in1_accept_o(in1_acc),
    .in0_instr_i(in0_instr), .in1_instr_i(in1_instr),
    .in0_pc_i(in0_pc), .in1_pc_i(in1_pc),
    .in0_info_i(in0_info), .in1_info_i(in1_info),
    .out0_valid_o(out0_v), .out1_valid_o(out1_v),
    .out0_accept_i(out0_acc), .out1_accept_i(out1_acc),
    .out0_instr_o(out0_instr), .out1_instr_o(out1_instr),
    .out0_pc_o(out0_pc), .out1_pc_o(out1_pc),
    .out0_info_o(out0_info), .out1_info_o(out1_info),
    .level_o(level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) assert (level <= 4'd8) else $error("FAIL level bound: level %0d exceeds 8", level);

  task automatic drive(input logic v0, input logic v1, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic a0, input logic a1);
    in0_v = v0; in1_v = v1; in0_pc = pc0; in1_pc = pc1;
    in0_instr = $urandom; in1_instr = $urandom;
    in0_info = 12'($urandom); in1_info = 12'($urandom);
    out0_acc = a0; out1_acc = a1;
  endtask

  task automatic tick();
    int n = model.size();
    if (rst || flush) model.delete();
    else begin
      if (out0_acc && n >= 1) begin
        void'(model.pop_front());
        if (out1_acc && n >= 2) void'(model.pop_front());
      end
      if (in0_v && n <= 7) model.push_back({in0_info, in0_pc, in0_instr});
      if (in1_v && n <= 6) model.push_back({in1_info, in1_pc, in1_instr});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 32'h10, 32'h14, 0, 0);
    rst = 1; tick(); rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
    total_cnt++; if ({out0_v, out1_v} !== 2'b00) $display("FAIL reset_valid: got %b want 00", {out0_v, out1_v}); else pass_cnt++;
    total_cnt++; if ({in0_acc, in1_acc} !== 2'b11) $display("FAIL reset_accept: got %b want 11", {in0_acc, in1_acc}); else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++; if (level !== 4'd8) $display("FAIL fill_level: got %0d want 8", level); else pass_cnt++;
    total_cnt++; if ({in0_acc, in1_acc} !== 2'b00) $display("FAIL fill_accept: got %b want 00", {in0_acc, in1_acc}); else pass_cnt++;
    total_cnt++; if (out0_pc !== 32'h100 || out1_pc !== 32'h104)
      $display("FAIL fill_pc: got %h/%h want 00000100/00000104", out0_pc, out1_pc); else pass_cnt++;
  endtask

  task automatic test_almost_full();
    drive(0, 0, 0, 0, 1, 0);
    tick();
    total_cnt++; if (level !== 4'd7) $display("FAIL af_level: got %0d want 7", level); else pass_cnt++;
    drive(1, 1, 32'h300, 32'h304, 0, 0);
    total_cnt++; if ({in0_acc, in1_acc} !== 2'b10) $display("FAIL af_accept: got %b want 10", {in0_acc, in1_acc}); else pass_cnt++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++; if (level !== 4'd8) $display("FAIL af_level_after: got %0d want 8", level); else pass_cnt++;
    while (model.size() > 0) begin
      total_cnt++; if ({out0_info, out0_pc, out0_instr} !== model[0])
        $display("FAIL af_drain: got pc %h want pc %h", out0_pc, model[0][63:32]); else pass_cnt++;
      drive(0, 0, 0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_lone_in1();
    rst = 1; tick(); rst = 0;
    drive(0, 1, 32'h0, 32'h200, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++; if ({out0_v, out1_v} !== 2'b10) $display("FAIL lone_valid: got %b want 10", {out0_v, out1_v}); else pass_cnt++;
    total_cnt++; if (out0_pc !== 32'h200) $display("FAIL lone_pc: got %h want 00000200", out0_pc); else pass_cnt++;
    total_cnt++; if ({out0_info, out0_pc, out0_instr} !== model[0]) $display("FAIL lone_entry: got %h want %h", {out0_info, out0_pc, out0_instr}, model[0]); else pass_cnt++;
  endtask

  task automatic test_out1_only();
    drive(1, 1, 32'h204, 32'h208, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    total_cnt++; if (level !== 4'd3) $display("FAIL o1_pre_level: got %0d want 3", level); else pass_cnt++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++; if (level !== 4'd3) $display("FAIL o1_level: got %0d want 3", level); else pass_cnt++;
    total_cnt++; if (out0_pc !== 32'h200 || out1_pc !== 32'h204)
      $display("FAIL o1_pc: got %h/%h want 00000200/00000204", out0_pc, out1_pc); else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(1, 1, 32'h20c, 32'h210, 0, 0);
    tick();
    drive(1, 0, 32'h800, 32'h0, 1, 1);
    flush = 1;
    total_cnt++; if (level !== 4'd5) $display("FAIL flush_pre_level: got %0d want 5", level); else pass_cnt++;
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++; if (level !== 4'd0) $display("FAIL flush_level: got %0d want 0", level); else pass_cnt++;
    total_cnt++; if ({out0_v, out1_v} !== 2'b00) $display("FAIL flush_valid: got %b want 00", {out0_v, out1_v}); else pass_cnt++;
    drive(1, 0, 32'h900, 32'h0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total_cnt++; if (out0_pc !== 32'h900 || level !== 4'd1)
      $display("FAIL flush_after: got pc %h level %0d want 00000900 level 1", out0_pc, level); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] next_pc, exp_pop_pc;
    int          pops, errs, n;
    rst = 1; tick(); rst = 0;
    next_pc = 32'h1000; exp_pop_pc = 32'h1000; pops = 0; errs = 0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, next_pc, 32'h0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
      if (!in0_v) in1_pc = next_pc;
      else in1_pc = next_pc + 4;
      n = model.size();
      if (level !== 4'(n) || out0_v !== (n >= 1) || out1_v !== (n >= 2) ||
          in0_acc !== (n <= 7) || in1_acc !== (n <= 6) ||
          (n >= 1 && {out0_info, out0_pc, out0_instr} !== model[0]) ||
          (n >= 2 && {out1_info, out1_pc, out1_instr} !== model[1])) begin
        if (errs < 5) $display("FAIL stream_cycle%0d: got level %0d pc %h/%h want level %0d", c, level, out0_pc, out1_pc, n);
        errs++;
      end
      if (out0_acc && n >= 1) begin
        if (model[0][63:32] !== exp_pop_pc) errs++;
        exp_pop_pc += 4; pops++;
        if (out1_acc && n >= 2) begin
          if (model[1][63:32] !== exp_pop_pc) errs++;
          exp_pop_pc += 4; pops++;
        end
      end
      if (in0_v && n <= 7) next_pc += 4;
      if (in1_v && n <= 6) next_pc += 4;
      tick();
    end
    total_cnt++; if (errs != 0) $display("FAIL stream_match: got %0d errors want 0", errs); else pass_cnt++;
    total_cnt++; if (pops < 32) $display("FAIL stream_wraps: got %0d pops want >= 32", pops); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_almost_full();
    test_lone_in1();
    test_out1_only();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
